// File: rtl/tt_pad_cfg_sequencer.sv
// tt_pad_cfg_sequencer: shadow/active control registers for the bidir user pads.
// A commit copies shadow to active one pad at a time with a stagger; safe_req forces all pads safe.
module tt_pad_cfg_sequencer #(
    parameter int NPADS   = 16,
    parameter int STAGGER = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_addr,
    input  logic [5:0]       cfg_data,
    input  logic             commit,
    input  logic             safe_req,
    output logic             busy,
    output logic             done,
    input  logic [NPADS-1:0] user_oe,
    output logic [NPADS-1:0] pad_oe,
    output logic [NPADS-1:0] pad_ie,
    output logic [NPADS-1:0] pad_sl,
    output logic [NPADS-1:0] pad_cs,
    output logic [NPADS-1:0] pad_pd,
    output logic [NPADS-1:0] pad_pu
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [5:0] SAFE    = 6'b000010;
    localparam int         CW      = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    logic [1:0]    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    shadow_q [NPADS];
    logic [5:0]    shadow_d [NPADS];
    logic [5:0]    active_q [NPADS];
    logic [5:0]    active_d [NPADS];
    logic [5:0]    sh_cur, ac_cur;
    logic          wr, chg, last;

    assign cfg_ready = (state_q == S_IDLE) && !safe_req;
    assign wr        = cfg_valid && cfg_ready;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign last      = idx_q == 4'(NPADS - 1);
    assign chg       = sh_cur != ac_cur;

    always_comb begin
        sh_cur = SAFE;
        ac_cur = SAFE;
        for (int i = 0; i < NPADS; i++) begin
            if (idx_q == 4'(i)) begin
                sh_cur = shadow_q[i];
                ac_cur = active_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        // out-of-range addresses match no pad, so the write is silently dropped
        for (int i = 0; i < NPADS; i++) begin
            if (wr && cfg_addr == 4'(i)) shadow_d[i] = cfg_data;
            if (state_q == S_APPLY && idx_q == 4'(i)) active_d[i] = shadow_q[i];
        end
        case (state_q)
            S_IDLE: if (commit) begin
                state_d = S_APPLY;
                idx_d   = 4'd0;
            end
            S_APPLY: begin
                if (last) state_d = S_DONE;
                else if (chg && STAGGER > 1) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(STAGGER - 1);
                end else idx_d = idx_q + 4'd1;
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_APPLY;
                    idx_d   = idx_q + 4'd1;
                end else cnt_d = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        if (safe_req) begin
            state_d = S_IDLE;
            for (int i = 0; i < NPADS; i++) active_d[i] = SAFE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NPADS; i++) begin
                shadow_q[i] <= SAFE;
                active_q[i] <= SAFE;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        pad_oe = '0;
        pad_ie = '0;
        pad_sl = '0;
        pad_cs = '0;
        pad_pd = '0;
        pad_pu = '0;
        for (int i = 0; i < NPADS; i++) begin
            pad_oe[i] = user_oe[i] & active_q[i][5];
            pad_ie[i] = active_q[i][4];
            pad_sl[i] = active_q[i][3];
            pad_cs[i] = active_q[i][2];
            pad_pd[i] = active_q[i][1];
            pad_pu[i] = active_q[i][0];
        end
    end
endmodule

// File: tb/tb_tt_pad_cfg_sequencer.sv
// tb_tt_pad_cfg_sequencer: checks reset, staggered commit timing, skips, blocking, safe override
// and same-cycle write+commit; a second NPADS=8 instance covers out-of-range writes.
module tb_tt_pad_cfg_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cfg_valid, cfg_ready, commit, safe_req, busy, done;
    logic [3:0]  cfg_addr;
    logic [5:0]  cfg_data;
    logic [15:0] user_oe, pad_oe, pad_ie, pad_sl, pad_cs, pad_pd, pad_pu;

    logic        s_cfg_valid, s_cfg_ready, s_commit, s_safe_req, s_busy, s_done;
    logic [3:0]  s_cfg_addr;
    logic [5:0]  s_cfg_data;
    logic [7:0]  s_user_oe, s_pad_oe, s_pad_ie, s_pad_sl, s_pad_cs, s_pad_pd, s_pad_pu;

    tt_pad_cfg_sequencer dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .commit(commit), .safe_req(safe_req),
        .busy(busy), .done(done), .user_oe(user_oe), .pad_oe(pad_oe), .pad_ie(pad_ie),
        .pad_sl(pad_sl), .pad_cs(pad_cs), .pad_pd(pad_pd), .pad_pu(pad_pu)
    );

    tt_pad_cfg_sequencer #(.NPADS(8), .STAGGER(4)) dut8 (
        .clk(clk), .rst(rst), .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
        .cfg_addr(s_cfg_addr), .cfg_data(s_cfg_data), .commit(s_commit), .safe_req(s_safe_req),
        .busy(s_busy), .done(s_done), .user_oe(s_user_oe), .pad_oe(s_pad_oe), .pad_ie(s_pad_ie),
        .pad_sl(s_pad_sl), .pad_cs(s_pad_cs), .pad_pd(s_pad_pd), .pad_pu(s_pad_pu)
    );

    typedef struct { int e; int p; } ev_t;
    typedef struct { logic [3:0] a; logic [5:0] d; logic u; logic [5:0] exp; } vec_t;

    ev_t         evq [$];
    vec_t        vq [$];
    vec_t        tbl [6];
    ev_t         ev;
    vec_t        r;
    int          n_chk = 0, n_fail = 0, edge_n = 0;
    int          k, at, n_done;
    logic [15:0] e_ie, e_pu, e_pd;

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit(output int ke);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        ke = edge_n;
    endtask

    task automatic wait_done(input int lim, output int a);
        a = -1;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (done) begin
                a = edge_n;
                break;
            end
        end
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cfg_valid = 0; cfg_addr = 0; cfg_data = 0; commit = 0; safe_req = 0; user_oe = '1;
        s_cfg_valid = 0; s_cfg_addr = 0; s_cfg_data = 0; s_commit = 0; s_safe_req = 0; s_user_oe = '1;
        tbl[0] = '{4'd0,  6'b100000, 1'b1, 6'b100000};
        tbl[1] = '{4'd7,  6'b100000, 1'b0, 6'b000000};
        tbl[2] = '{4'd15, 6'b011110, 1'b1, 6'b011110};
        tbl[3] = '{4'd1,  6'b000010, 1'b1, 6'b000010};
        tbl[4] = '{4'd12, 6'b111111, 1'b0, 6'b011111};
        tbl[5] = '{4'd6,  6'b101101, 1'b1, 6'b101101};
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_pd", pad_pd, 16'hFFFF);
        chk("rst_oe", pad_oe, 16'h0);
        chk("rst_other", pad_ie | pad_sl | pad_cs | pad_pu, 16'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst8_pd", s_pad_pd, 8'hFF);

        // full staggered commit, every pad changes
        for (int i = 0; i < 16; i++) wr(4'(i), 6'b110001);
        do_commit(k);
        for (int i = 0; i < 16; i++) evq.push_back('{k + 1 + 4 * i, i});
        e_ie = '0; e_pu = '0; e_pd = '1;
        for (int t = 0; t < 63; t++) begin
            tick();
            while (evq.size() > 0 && evq[0].e == edge_n) begin
                ev = evq.pop_front();
                e_ie[ev.p] = 1'b1;
                e_pu[ev.p] = 1'b1;
                e_pd[ev.p] = 1'b0;
            end
            chk("stag_ie", pad_ie, e_ie);
            chk("stag_pu", pad_pu, e_pu);
            chk("stag_pd", pad_pd, e_pd);
            chk("stag_oe", pad_oe, e_ie);
            chk("stag_done", done, 32'(edge_n == k + 61));
            chk("stag_busy", busy, 32'(edge_n < k + 62));
        end
        chk("stag_evq_empty", evq.size(), 0);

        // only pads 3 and 9 change, the rest are skipped
        wr(4'd3, 6'b010000);
        wr(4'd9, 6'b010000);
        do_commit(k);
        run_to(k + 3);
        chk("skip_p3_before", pad_pu[3], 1);
        run_to(k + 4);
        chk("skip_p3", {pad_oe[3], pad_ie[3], pad_pu[3]}, 3'b010);
        run_to(k + 12);
        chk("skip_p9_before", pad_oe[9], 1);
        run_to(k + 13);
        chk("skip_p9", {pad_oe[9], pad_ie[9], pad_pu[9]}, 3'b010);
        chk("skip_others", pad_oe, 16'hFDF7);
        wait_done(20, at);
        chk("skip_done_edge", at, k + 22);
        tick();

        // writes and a second commit while busy are ignored
        do_commit(k);
        n_done = 0;
        for (int t = 0; t < 40; t++) begin
            if (t == 2) begin
                cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 6'b000000; commit = 1'b1;
                chk("busy_ready", cfg_ready, 0);
            end
            if (t == 5) begin
                cfg_valid = 1'b0; commit = 1'b0;
            end
            tick();
            if (done) n_done++;
        end
        chk("busy_one_done", n_done, 1);
        do_commit(k);
        wait_done(30, at);
        chk("busy_shadow_kept", {pad_oe[0], pad_pu[0]}, 2'b11);
        tick();

        // out-of-range address on an 8-pad instance
        s_cfg_valid = 1'b1; s_cfg_addr = 4'd15; s_cfg_data = 6'b111111;
        chk("n8_ready15", s_cfg_ready, 1);
        tick();
        s_cfg_addr = 4'd2; s_cfg_data = 6'b000001;
        tick();
        s_cfg_valid = 1'b0; s_commit = 1'b1;
        tick();
        s_commit = 1'b0;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_done) begin
                at = edge_n;
                break;
            end
        end
        chk("n8_done_seen", 32'(at >= 0), 1);
        chk("n8_pu", s_pad_pu, 8'h04);
        chk("n8_pd", s_pad_pd, 8'hFB);
        chk("n8_oe_ie", s_pad_oe | s_pad_ie, 8'h00);

        // safe override in idle, then mid-commit, then restore
        safe_req = 1'b1;
        tick();
        safe_req = 1'b0;
        chk("safe_idle_pd", pad_pd, 16'hFFFF);
        chk("safe_idle_ie", pad_ie, 16'h0);
        do_commit(k);
        run_to(k + 20);
        chk("pre_safe_p4", pad_pu[4], 1);
        chk("pre_safe_p5", pad_pu[5], 0);
        safe_req = 1'b1;
        tick();
        chk("safe_pd", pad_pd, 16'hFFFF);
        chk("safe_pu", pad_pu, 16'h0);
        chk("safe_oe", pad_oe, 16'h0);
        chk("safe_busy", busy, 0);
        chk("safe_ready", cfg_ready, 0);
        commit = 1'b1;
        tick();
        chk("safe_commit_blocked", busy, 0);
        commit = 1'b0;
        safe_req = 1'b0;
        n_done = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (done) n_done++;
        end
        chk("safe_no_done", n_done, 0);
        do_commit(k);
        wait_done(80, at);
        chk("restore_done_edge", at, k + 61);
        chk("restore_ie", pad_ie, 16'hFFFF);
        chk("restore_pu", pad_pu, 16'hFDF7);
        chk("restore_pd", pad_pd, 16'h0);
        chk("restore_oe", pad_oe, 16'hFDF7);
        tick();

        // write and commit in the same cycle
        cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 6'b001100; commit = 1'b1;
        tick();
        cfg_valid = 1'b0; commit = 1'b0;
        wait_done(80, at);
        chk("same_cycle_p0", {pad_oe[0], pad_ie[0], pad_sl[0], pad_cs[0], pad_pd[0], pad_pu[0]}, 6'b001100);

        // table of single-pad writes, expectations queued at commit and popped on done
        foreach (tbl[i]) begin
            tick();
            user_oe = {16{tbl[i].u}};
            wr(tbl[i].a, tbl[i].d);
            commit = 1'b1;
            tick();
            commit = 1'b0;
            vq.push_back(tbl[i]);
            wait_done(80, at);
            chk("tbl_done_seen", 32'(at >= 0), 1);
            r = vq.pop_front();
            chk($sformatf("tbl_pad%0d", r.a),
                {pad_oe[r.a], pad_ie[r.a], pad_sl[r.a], pad_cs[r.a], pad_pd[r.a], pad_pu[r.a]}, r.exp);
        end
        user_oe = '1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
